// File: rtl/i2c_config_sequencer.sv
// Write-only I2C master that streams NUM_CMDS 16-bit register words to one slave,
// retrying NACKed frames. Define I2C_CLK_STRETCH_EN to add i_sclk for slave clock stretching.
module i2c_config_sequencer #(
  parameter int          NUM_CMDS  = 7,
  parameter int          CLK_DIV   = 4,
  parameter logic [7:0]  DEV_ADDR  = 8'h34,
  parameter int          MAX_RETRY = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [16*NUM_CMDS-1:0]  i_cmds,
  input  logic                    i_sdat,
`ifdef I2C_CLK_STRETCH_EN
  input  logic                    i_sclk,
`endif
  output logic                    o_sclk,
  output logic                    o_sdat,
  output logic                    o_oen,
  output logic                    o_busy,
  output logic                    o_finished,
  output logic                    o_error,
  output logic [5:0]              o_cmd_idx
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          hi;
  logic [4:0]    slot;
  logic [3:0]    retry;
  logic          nack;

  logic [15:0]   cmd;
  logic [26:0]   frame;
  logic [4:0]    nxt_slot;
  logic          nxt_ack, nxt_bit, cnt_end, hi_adv, nack_now;

`ifdef I2C_CLK_STRETCH_EN
  assign hi_adv = i_sclk;
`else
  assign hi_adv = 1'b1;
`endif

  always_comb begin
    cmd = '0;
    for (int k = 0; k < NUM_CMDS; k++)
      if (o_cmd_idx == 6'(k)) cmd = i_cmds[16*k +: 16];
  end

  // ACK slots carry a dummy 1; o_oen=0 there so it never reaches the bus
  assign frame    = {DEV_ADDR, 1'b1, cmd[15:8], 1'b1, cmd[7:0], 1'b1};
  assign nxt_slot = (state == S_START) ? 5'd0 : slot + 5'd1;
  assign nxt_ack  = (nxt_slot == 5'd8) || (nxt_slot == 5'd17) || (nxt_slot == 5'd26);
  assign nxt_bit  = frame[5'd26 - nxt_slot];
  assign cnt_end  = (cnt == CW'(CLK_DIV - 1));
  assign nack_now = (state == S_ACK) && i_sdat;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hi         <= 1'b0;
      slot       <= '0;
      retry      <= '0;
      nack       <= 1'b0;
      o_sclk     <= 1'b1;
      o_sdat     <= 1'b1;
      o_oen      <= 1'b1;
      o_busy     <= 1'b0;
      o_finished <= 1'b0;
      o_error    <= 1'b0;
      o_cmd_idx  <= '0;
    end else begin
      o_finished <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          state     <= S_START;
          o_busy    <= 1'b1;
          o_error   <= 1'b0;
          o_cmd_idx <= '0;
          retry     <= '0;
          cnt       <= '0;
          o_sclk    <= 1'b1;
          o_sdat    <= 1'b0;
          o_oen     <= 1'b1;
        end
        S_START, S_BIT, S_ACK: begin
          if (state != S_START && !hi) begin
            cnt <= cnt_end ? '0 : cnt + 1'b1;
            if (cnt_end) begin
              hi     <= 1'b1;
              o_sclk <= 1'b1;
            end
          end else if (hi_adv) begin
            if (!cnt_end) cnt <= cnt + 1'b1;
            else begin
              cnt <= '0;
              hi  <= 1'b0;
              if (state != S_START && (nack_now || slot == 5'd26)) begin
                state  <= S_STOP;
                nack   <= nack_now;
                o_sclk <= 1'b0;
                o_sdat <= 1'b0;
                o_oen  <= 1'b1;
              end else begin
                state  <= nxt_ack ? S_ACK : S_BIT;
                slot   <= nxt_slot;
                o_sclk <= 1'b0;
                o_sdat <= nxt_ack ? 1'b1 : nxt_bit;
                o_oen  <= ~nxt_ack;
              end
            end
          end
        end
        // low phase, then SCL-high phase, then SDA rises into GAP
        S_STOP: begin
          if (!hi) begin
            cnt <= cnt_end ? '0 : cnt + 1'b1;
            if (cnt_end) begin
              hi     <= 1'b1;
              o_sclk <= 1'b1;
            end
          end else if (hi_adv) begin
            cnt <= cnt_end ? '0 : cnt + 1'b1;
            if (cnt_end) begin
              state  <= S_GAP;
              hi     <= 1'b0;
              o_sdat <= 1'b1;
            end
          end
        end
        S_GAP: begin
          cnt <= cnt_end ? '0 : cnt + 1'b1;
          if (cnt_end) begin
            if (nack && retry < 4'(MAX_RETRY)) begin
              retry  <= retry + 1'b1;
              state  <= S_START;
              o_sdat <= 1'b0;
            end else if (nack) begin
              state   <= S_ERR;
              o_error <= 1'b1;
              o_busy  <= 1'b0;
            end else if (o_cmd_idx == 6'(NUM_CMDS - 1)) begin
              retry      <= '0;
              o_cmd_idx  <= '0;
              state      <= S_DONE;
              o_finished <= 1'b1;
              o_busy     <= 1'b0;
            end else begin
              retry     <= '0;
              o_cmd_idx <= o_cmd_idx + 1'b1;
              state     <= S_START;
              o_sdat    <= 1'b0;
            end
          end
        end
        S_DONE, S_ERR: state <= S_IDLE;
        default:       state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: bus-level slave with scripted ACK/NACK decisions,
// frame-level reference model, table vectors, random runs and reset/stretch corners.
module tb_i2c_config_sequencer;
  localparam int         NC = 2;
  localparam int         CD = 4;
  localparam int         MR = 3;
  localparam logic [7:0] DA = 8'h34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst, i_start, i_sdat;
  logic [31:0] i_cmds;
  logic        o_sclk, o_sdat, o_oen, o_busy, o_finished, o_error;
  logic [5:0]  o_cmd_idx;
  logic        slave_sda = 1'b1;
  logic        sda_line;
  assign sda_line = (o_oen ? o_sdat : 1'b1) & slave_sda;
  assign i_sdat   = sda_line;
`ifdef I2C_CLK_STRETCH_EN
  logic hold = 1'b0;
  logic i_sclk;
  assign i_sclk = o_sclk & ~hold;
`endif

  i2c_config_sequencer #(.NUM_CMDS(NC), .CLK_DIV(CD), .DEV_ADDR(DA), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_cmds(i_cmds), .i_sdat(i_sdat),
`ifdef I2C_CLK_STRETCH_EN
    .i_sclk(i_sclk),
`endif
    .o_sclk(o_sclk), .o_sdat(o_sdat), .o_oen(o_oen), .o_busy(o_busy),
    .o_finished(o_finished), .o_error(o_error), .o_cmd_idx(o_cmd_idx));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bus monitor + slave: decodes START/STOP/bytes, answers each byte from dec[]
  logic        mon_clr = 1'b0;
  logic [31:0] dec = '0;
  int          dec_ptr, bitcnt, starts_seen, stops_seen, fin_pulses, bus_err;
  logic [7:0]  sh;
  logic [7:0]  got_q[$];
  logic        p_sc = 1'b1, p_sda = 1'b1, ack_drv = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      got_q.delete();
      dec_ptr = 0; bitcnt = 0; starts_seen = 0; stops_seen = 0; fin_pulses = 0; bus_err = 0;
      slave_sda = 1'b1; ack_drv = 1'b0; p_sc = 1'b1; p_sda = 1'b1;
    end else begin
      if (o_finished) fin_pulses++;
      if (p_sc && o_sclk && p_sda && !sda_line) begin
        starts_seen++; bitcnt = 0;
      end else if (p_sc && o_sclk && !p_sda && sda_line) begin
        stops_seen++;
      end else if (!p_sc && o_sclk) begin
        if (bitcnt < 8) begin
          if (!o_oen) bus_err++;
          sh = {sh[6:0], sda_line};
          bitcnt++;
          if (bitcnt == 8) got_q.push_back(sh);
        end else begin
          if (o_oen) bus_err++;
          bitcnt = 0;
        end
      end else if (p_sc && !o_sclk) begin
        if (bitcnt == 8 && !ack_drv) begin
          slave_sda = (dec_ptr < 32) ? dec[dec_ptr] : 1'b0;
          dec_ptr++;
          ack_drv = 1'b1;
        end else if (ack_drv) begin
          slave_sda = 1'b1;
          ack_drv   = 1'b0;
        end
      end
      p_sc  = o_sclk;
      p_sda = sda_line;
    end
  end

  typedef struct {
    logic [15:0] c0, c1;
    logic [31:0] dec;
    int          mid;
    int          cyc;
    logic        fin, err;
    logic [5:0]  idx;
    int          starts;
  } vec_t;

  vec_t tbl[8];

  // Frame-level model: each attempt costs CLK_DIV*(START + 18 per byte sent + STOP/GAP)
  task automatic run_case(input vec_t v, input bit has_exp, input int st_lo, input int st_hi,
                          input int extra);
    logic [7:0]  q[$];
    logic [15:0] w[NC];
    logic [7:0]  b;
    int m_cyc = 0, m_starts = 0, m_idx = 0, p = 0, cyc;
    logic m_err = 1'b0, fin, err, ok, nk;
    int retry, sent;
    logic [5:0] idx;
    w[0] = v.c0; w[1] = v.c1;
    for (int f = 0; f < NC && !m_err; f++) begin
      retry = 0; ok = 1'b0;
      while (!ok && !m_err) begin
        m_starts++; sent = 0; nk = 1'b0;
        for (int k = 0; k < 3; k++) begin
          b = (k == 0) ? DA : (k == 1) ? w[f][15:8] : w[f][7:0];
          q.push_back(b);
          sent++;
          if (p < 32 && v.dec[p]) nk = 1'b1;
          p++;
          if (nk) break;
        end
        m_cyc += CD * (1 + 18 * sent + 3);
        if (!nk) ok = 1'b1;
        else if (retry < MR) retry++;
        else begin m_err = 1'b1; m_idx = f; end
      end
    end

    i_cmds = {v.c1, v.c0};
    dec    = v.dec;
    @(posedge clk) mon_clr = 1'b1;
    @(posedge clk) mon_clr = 1'b0;
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    chk("busy_rise", o_busy, 1);
    chk("error_cleared_on_start", o_error, 0);
    cyc = 0;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
`ifdef I2C_CLK_STRETCH_EN
      hold = (cyc >= st_lo && cyc < st_hi);
`endif
      i_start = (cyc == v.mid);
      if (o_finished || o_error) break;
    end
`ifdef I2C_CLK_STRETCH_EN
    hold = 1'b0;
`endif
    chk("done_within_budget", cyc < 4000, 1);
    fin = o_finished; err = o_error; idx = o_cmd_idx;
    chk("busy_low_at_end", o_busy, 0);
    i_start = 1'b1;                       // start in the DONE/ERR cycle must be ignored
    @(negedge clk) i_start = 1'b0;
    chk("start_in_done_ignored", o_busy, 0);
    chk("finished_one_cycle", o_finished, 0);
    repeat (3) @(negedge clk);
    chk("finished_pulse_count", fin_pulses, m_err ? 0 : 1);
    chk("error_sticky", o_error, m_err);

    chk("model_cycles", cyc, m_cyc + extra);
    chk("model_finished", fin, !m_err);
    chk("model_error", err, m_err);
    if (m_err) chk("model_fail_idx", idx, m_idx);
    chk("model_starts", starts_seen, m_starts);
    chk("model_stops", stops_seen, m_starts);
    chk("bus_oen_protocol", bus_err, 0);
    chk("byte_count", got_q.size(), q.size());
    for (int i = 0; i < q.size(); i++)
      chk($sformatf("byte%0d", i), (i < got_q.size()) ? got_q[i] : 8'hxx, q[i]);
    if (has_exp) begin
      chk("tbl_cycles", cyc, v.cyc + extra);
      chk("tbl_finished", fin, v.fin);
      chk("tbl_error", err, v.err);
      if (v.err) chk("tbl_fail_idx", idx, v.idx);
      chk("tbl_starts", starts_seen, v.starts);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t r;
    int   c;
    tbl[0] = '{16'h1E00, 16'h0097, 32'h0,   0,   464, 1'b1, 1'b0, 6'd0, 2};
    tbl[1] = '{16'h1E00, 16'h0097, 32'h1,   0,   552, 1'b1, 1'b0, 6'd0, 3};
    tbl[2] = '{16'h1E00, 16'h0097, 32'hFFFF_FFFF, 0, 352, 1'b0, 1'b1, 6'd0, 4};
    tbl[3] = '{16'h1E00, 16'h0097, 32'h0,   100, 464, 1'b1, 1'b0, 6'd0, 2};
    tbl[4] = '{16'h1234, 16'hABCD, 32'h10,  0,   624, 1'b1, 1'b0, 6'd0, 3};
    tbl[5] = '{16'h5A5A, 16'hC3FF, 32'h4,   0,   696, 1'b1, 1'b0, 6'd0, 3};
    tbl[6] = '{16'h00FF, 16'h8001, 32'h1C7, 0,   992, 1'b1, 1'b0, 6'd0, 8};
    tbl[7] = '{16'h7F80, 16'h0102, 32'h78,  0,   584, 1'b0, 1'b1, 6'd1, 5};

    i_rst = 1'b1; i_start = 1'b0; i_cmds = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", o_sclk, 1);
    chk("rst_sdat", o_sdat, 1);
    chk("rst_oen", o_oen, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_finished", o_finished, 0);
    chk("rst_error", o_error, 0);
    chk("rst_cmd_idx", o_cmd_idx, 0);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_case(tbl[i], 1'b1, 0, 0, 0);

    // reset during frame 1's first ACK slot (cycles 300..307 after busy rises)
    i_cmds = {16'h0097, 16'h1E00};
    dec    = '0;
    @(posedge clk) mon_clr = 1'b1;
    @(posedge clk) mon_clr = 1'b0;
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    c = 0;
    while (c < 302) begin @(negedge clk); c++; end
    chk("pre_rst_in_ack", o_oen, 0);
    chk("pre_rst_frame1", o_cmd_idx, 1);
    i_rst = 1'b1;
    @(negedge clk);
    chk("midrst_sclk", o_sclk, 1);
    chk("midrst_sdat", o_sdat, 1);
    chk("midrst_oen", o_oen, 1);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_cmd_idx", o_cmd_idx, 0);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);
    run_case(tbl[0], 1'b1, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      r.c0  = 16'($urandom);
      r.c1  = 16'($urandom);
      r.dec = $urandom & $urandom;
      r.mid = (i == 2) ? 50 : 0;
      r.cyc = 0; r.fin = 1'b0; r.err = 1'b0; r.idx = '0; r.starts = 0;
      run_case(r, 1'b0, 0, 0, 0);
    end

`ifdef I2C_CLK_STRETCH_EN
    // stall the SCL-high half of bit 3 of frame 0 for 10 cycles
    run_case(tbl[0], 1'b1, 32, 42, 10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
